// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: state and strobe definitions for the program loader.
// Shared by the loader and the surrounding FPGA top level.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    VERIFY,
    RELEASE
  } loader_state_t;

  localparam logic [3:0] WSTRB_WORD = 4'b1111;
  localparam logic [3:0] WSTRB_READ = 4'b0000;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/mem_loader.sv
// mem_loader: writes a program image over the native memory bus while the
// CPU is held in reset. Define MEM_LOADER_VERIFY_EN for read-back checking.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_data,
  input  logic                             in_last,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_count,
  output logic                             bus_grant,
  output logic                             cpu_reset_n,
  output logic                             mem_valid,
  output logic                             mem_instr,
  input  logic                             mem_ready,
  output logic [31:0]                      mem_addr,
  output logic [31:0]                      mem_wdata,
  output logic [3:0]                       mem_wstrb,
  input  logic [31:0]                      mem_rdata
);

  localparam int            CW  = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_WORDS);

  loader_state_t r_state, w_state;
  logic [CW-1:0] r_count, w_count;
  logic          r_error, w_error;
  logic          r_cpu_rst_n, w_cpu_rst_n;
  logic [31:0]   r_addr, w_addr;
  logic [31:0]   r_wdata, w_wdata;
  logic          r_last, w_last;

`ifndef MEM_LOADER_VERIFY_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_error     <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_error     <= w_error;
      r_cpu_rst_n <= w_cpu_rst_n;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_last      <= w_last;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_error     = r_error;
    w_cpu_rst_n = r_cpu_rst_n;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_last      = r_last;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_count     = '0;
          w_error     = 1'b0;
          w_cpu_rst_n = 1'b0;
          w_state     = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          // A full image consumes the extra word and ends the session.
          if (r_count == CAP) begin
            w_error = 1'b1;
            w_state = RELEASE;
          end else begin
            w_wdata = in_data;
            w_last  = in_last;
            w_addr  = word_addr(BASE_ADDR, 32'(r_count));
            w_state = WRITE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          w_count = r_count + 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
          w_state = VERIFY;
`else
          w_state = r_last ? RELEASE : ACCEPT;
`endif
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      VERIFY: begin
        if (mem_ready) begin
          if (mem_rdata != r_wdata) w_error = 1'b1;
          w_state = r_last ? RELEASE : ACCEPT;
        end
      end
`endif
      RELEASE: begin
        w_cpu_rst_n = ~r_error;
        w_state     = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign in_ready    = (r_state == ACCEPT);
  assign mem_valid   = (r_state == WRITE) || (r_state == VERIFY);
  assign mem_wstrb   = (r_state == WRITE) ? WSTRB_WORD : WSTRB_READ;
  assign mem_instr   = 1'b0;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = (r_state != IDLE);
  assign bus_grant   = busy && (r_state != RELEASE);
  assign done        = (r_state == RELEASE);
  assign error       = r_error;
  assign word_count  = r_count;
  assign cpu_reset_n = r_cpu_rst_n;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized sessions against a counting model of the loader
// plus a memory responder with random waits and stray ready pulses.
module tb_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAX  = 8;
  localparam int          CW   = $clog2(MAX + 1);
`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          busy, done, error;
  logic [CW-1:0] word_count;
  logic          bus_grant, cpu_reset_n, mem_valid, mem_instr;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = '0;

  mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .busy(busy), .done(done), .error(error),
    .word_count(word_count), .bus_grant(bus_grant),
    .cpu_reset_n(cpu_reset_n), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Memory responder
  logic [31:0] mem [0:63];
  int wait_cfg = 0;
  int corrupt_idx = -1;
  bit spur_en = 1'b0;
  int wr_total = 0;
  int done_total = 0;
  int wcnt = 0;
  int cur_wait = 0;
  bit new_txn = 1'b1;

  always @(posedge clk) begin
    int idx;
    #1;
    idx = int'((mem_addr - BASE) >> 2) & 63;
    if (reset) begin
      mem_ready = 1'b0;
      new_txn = 1'b1;
    end else if (mem_valid) begin
      if (new_txn) begin
        cur_wait = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        wcnt = 0;
        new_txn = 1'b0;
      end
      if (wcnt >= cur_wait) begin
        mem_ready = 1'b1;
        new_txn = 1'b1;
        mem_rdata = mem[idx] ^ ((idx == corrupt_idx) ? 32'd1 : 32'd0);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ready = spur_en && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      new_txn = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready && mem_wstrb == 4'hF) begin
      mem[int'((mem_addr - BASE) >> 2) & 63] = mem_wdata;
      wr_total++;
    end
    if (!reset && done) done_total++;
  end

  // Model: counts of accepted words, completed writes and completed reads
  bit m_act = 0, m_rel = 0, m_err = 0, m_cpu = 0;
  int m_acc = 0, m_wr = 0, m_rd = 0;
  logic [31:0] m_w [0:15];
  bit m_l [0:15];

  always @(negedge clk) begin
    bit pw, pr, eg, ev, er;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_grant", bus_grant, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_cpu_n", cpu_reset_n, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_count", word_count, 0);
      m_act = 0; m_rel = 0; m_err = 0; m_cpu = 0;
      m_acc = 0; m_wr = 0; m_rd = 0;
    end else begin
      pw = m_acc > m_wr;
      pr = VER && (m_wr > m_rd);
      eg = m_act && !m_rel;
      ev = eg && (pw || pr);
      er = eg && !(pw || pr);
      chk("busy", busy, m_act);
      chk("bus_grant", bus_grant, eg);
      chk("done", done, m_rel);
      chk("in_ready", in_ready, er);
      chk("mem_valid", mem_valid, ev);
      chk("mem_instr", mem_instr, 0);
      chk("mem_wstrb", mem_wstrb, (ev && pw) ? 32'hF : 32'h0);
      chk("word_count", word_count, m_wr);
      chk("error", error, m_err);
      chk("cpu_reset_n", cpu_reset_n, m_cpu);
      if (ev && pw) begin
        chk("w_addr", mem_addr, BASE + 32'(4 * m_wr));
        chk("w_data", mem_wdata, m_w[m_wr]);
      end
      if (ev && !pw) chk("r_addr", mem_addr, BASE + 32'(4 * m_rd));
      if (m_rel) begin
        m_rel = 0; m_act = 0; m_cpu = !m_err;
      end else if (!m_act) begin
        if (start) begin
          m_act = 1; m_acc = 0; m_wr = 0; m_rd = 0; m_err = 0; m_cpu = 0;
        end
      end else if (er && in_valid) begin
        if (m_wr == MAX) begin
          m_err = 1; m_rel = 1;
        end else begin
          m_w[m_acc] = in_data; m_l[m_acc] = in_last; m_acc++;
        end
      end else if (ev && mem_ready) begin
        if (pw) begin
          m_wr++;
          if (!VER && m_l[m_wr-1]) m_rel = 1;
        end else begin
          if (mem_rdata !== m_w[m_rd]) m_err = 1;
          m_rd++;
          if (m_l[m_rd-1]) m_rel = 1;
        end
      end
    end
  end

  // Stimulus
  logic [31:0] s_words [0:15];
  logic [31:0] img [0:4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input int n, input bit use_img,
                             input int gmin, input int gmax,
                             input bit spur, input bit abort2);
    int lim, wr0, dn0, exp_wr, guard;
    bit hs, seen, exp_err;
    for (int i = 0; i < 16; i++)
      s_words[i] = (use_img && i < 5) ? img[i] : $urandom;
    lim = (n > MAX) ? MAX + 1 : n;
    wr0 = wr_total;
    dn0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < lim; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        start = spur && ($urandom_range(0, 2) == 0);
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = s_words[i];
      in_last  = (i == n - 1);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 200) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        guard++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!hs) begin
        n_fail++;
        $display("FAIL accept_timeout: word %0d never accepted", i);
        return;
      end
      if (abort2 && i == 1) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        return;
      end
    end
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      seen = done;
      guard++;
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done expected done");
    end
    tick();
    @(negedge clk);
    exp_wr  = (n > MAX) ? MAX : n;
    exp_err = (n > MAX) || (VER && corrupt_idx >= 0 && corrupt_idx < exp_wr);
    chk("s_word_count", word_count, exp_wr);
    chk("s_error", error, exp_err);
    chk("s_cpu_n", cpu_reset_n, !exp_err);
    chk("s_writes", wr_total - wr0, exp_wr);
    chk("s_done_pulses", done_total - dn0, 1);
    for (int i = 0; i < exp_wr; i++)
      chk("s_mem", mem[i], s_words[i]);
    tick();
  endtask

  initial begin
    img[0] = 32'h00A00093;
    img[1] = 32'h00108133;
    img[2] = 32'h002081B3;
    img[3] = 32'h08302023;
    img[4] = 32'hFF1FF06F;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    wait_cfg = 0;
    run_session(5, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("img_word3", mem[3], 32'h08302023);
    chk("img_count", word_count, 5);

    wait_cfg = 3;
    spur_en = 1'b1;
    run_session(6, 1'b0, 0, 2, 1'b0, 1'b0);

    wait_cfg = -1;
    run_session(MAX + 1, 1'b0, 0, 2, 1'b0, 1'b0);
    chk("ovf_count", word_count, MAX);
    chk("ovf_cpu_held", cpu_reset_n, 0);

    wait_cfg = 3;
    run_session(5, 1'b0, 0, 0, 1'b0, 1'b1);
    wait_cfg = 1;
    run_session(3, 1'b0, 0, 1, 1'b0, 1'b0);

    corrupt_idx = 2;
    wait_cfg = -1;
    run_session(5, 1'b0, 0, 2, 1'b0, 1'b0);
    corrupt_idx = -1;

    run_session(5, 1'b0, 7, 7, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      corrupt_idx = ($urandom_range(0, 1) == 0) ? -1
                    : int'($urandom_range(0, MAX - 1));
      run_session($urandom_range(1, MAX + 1), 1'b0, 0, 3, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got no end expected end");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Synthesizable bus initiator that writes a program image into memory over the PicoRV32 native memory interface while the CPU is held in reset, then releases the CPU. It sits between a word-stream source (host link, ROM, bench) and the `bram_controller` write port, sharing that port with the CPU through an external mux driven by `bus_grant`. It replaces bench-driven memory preloading with hardware that the FPGA top level can use.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written
- `MAX_WORDS`, 256, capacity; words beyond this are rejected
- `clk`  in  1  clock
- `reset`  in  1  one clock; reset is asynchronous and active-high
- `start`  in  1  one-cycle pulse; begins a load session
- `in_valid`  in  1  source word valid
- `in_ready`  out  1  loader accepts the word this cycle
- `in_data`  in  32  program word
- `in_last`  in  1  marks the final word of the image
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse at session end
- `error`  out  1  sticky; overflow or verify mismatch; cleared by `start`
- `word_count`  out  $clog2(MAX_WORDS+1)  words written this session
- `bus_grant`  out  1  high: memory mux selects the loader
- `cpu_reset_n`  out  1  CPU reset; low holds the CPU
- `mem_valid`, `mem_instr`  out  1 each  native bus request; `mem_instr` tied 0
- `mem_ready`  in  1  responder completion
- `mem_addr`, `mem_wdata`  out  32 each  word address/data
- `mem_wstrb`  out  4  4'b1111 on writes, 4'b0000 on reads
- `mem_rdata`  in  32  read data (used only when the verify feature is enabled)

## Operation
- States: IDLE, ACCEPT, WRITE, VERIFY, RELEASE.
- IDLE: `start` → clear `word_count` and `error`, assert `bus_grant`, drive `cpu_reset_n` low, go to ACCEPT. `start` in any other state is ignored.
- ACCEPT: `in_ready`=1. On `in_valid`: latch `in_data` and `in_last`, then go to WRITE with `mem_addr`=BASE_ADDR+4*`word_count`. If `word_count`==MAX_WORDS, the word is consumed, `error` is set, and the state goes to RELEASE.
- WRITE: `mem_valid`=1. Addr, data, and strobe stay stable until a cycle with `mem_ready`=1. In that cycle `word_count` increments. Next state: VERIFY (if enabled), else RELEASE if the latched last flag is set, else ACCEPT.
- VERIFY: read the same address with `mem_wstrb`=0. On `mem_ready`, compare `mem_rdata` to the latched word; a mismatch sets `error`. Then go to RELEASE if last, else ACCEPT.
- RELEASE: one cycle. Drop `bus_grant`, pulse `done`, go to IDLE. `cpu_reset_n` goes high on the following cycle, and only when `error`=0. On error, the CPU stays held.
- Address arithmetic: 32-bit, wraps modulo 2^32. No alignment check beyond BASE_ADDR[1:0] being zero.

## Timing
- Reset values: `cpu_reset_n`=0, `bus_grant`=0, `busy`=0, `done`=0, `error`=0, `in_ready`=0, `mem_valid`=0, `mem_addr`/`mem_wdata`=0, `mem_wstrb`=0, `word_count`=0.
- `start` at cycle N → `busy`/`bus_grant` high and `in_ready` high at N+1.
- A word accepted at cycle N → `mem_valid` high at N+1. A handshake at cycle M → `mem_valid` low at M+1, and `in_ready` high at M+1.
- Throughput: one word per 2+L cycles (L = responder wait cycles), or 3+2L with verify enabled.
- `mem_valid` is never deasserted before `mem_ready` is seen.
- `mem_ready` while `mem_valid`=0 is ignored.
- Reset asserted mid-transaction: the session aborts immediately, outputs return to their reset values, and the partial image stays in memory.
- `in_last` arriving together with the overflow condition: the overflow path wins.

## Configuration
- `MEM_LOADER_VERIFY_EN` defined: the VERIFY state exists and each word is read back and compared; a mismatch sets `error`.
- Undefined: VERIFY is removed, `mem_rdata` is unused, and the `error` source is overflow only.

## Structure
- Shared package `mem_loader_pkg`: state enum `loader_state_t`, `WSTRB_WORD`=4'b1111, `WSTRB_READ`=4'b0000.
- The bus mux (loader vs. CPU on the `bram_controller` inputs) is a natural sub-module, `mem_bus_mux`, selected by `bus_grant`. It is instantiated at the top level, not inside `mem_loader`.

## Test plan
- 5-word image (addi x1,x0,10 / add x2,x1,x1 / add x3,x1,x2 / sw x3,0x80(x0) / jal x0,-16), `in_last` on word 5, zero-wait responder → memory words 0x00–0x10 match, `word_count`=5, `done` pulses once, `cpu_reset_n` rises, and after 1000 ns mem[0x80]=30.
- Responder inserting 3 wait cycles → `mem_addr`/`mem_wdata` stable while `mem_valid` is high; exactly one write per word.
- MAX_WORDS=4, 5 words sent → `error`=1, 4 words written, `cpu_reset_n` stays 0, `done` pulses.
- `reset` pulsed during the WRITE of word 2 → all outputs at reset values the next cycle; a new `start` reloads from BASE_ADDR.
- With `MEM_LOADER_VERIFY_EN`, the responder corrupts word 3 on read (bit 0 flipped) → `error`=1, CPU held; without the macro, the same run gives `error`=0.
- `start` pulsed while busy and `in_valid` gaps of 7 cycles → session unaffected; `in_ready` stays high during the gaps.
